// File: rtl/data_store_tx.sv
// Single-frame transmit payload buffer: stores 16-bit words in a BRAM, then
// streams the committed frame MSB-first as N-bit symbols with no gaps.
module data_store_tx #(
  parameter int N     = 2,
  parameter int DEPTH = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         axiiv,
  input  logic [15:0]  axiid,
  input  logic         axiil,
  output logic         wr_ready,
  input  logic         tx_start,
  output logic         axiov,
  output logic [N-1:0] axiod,
  output logic         frame_ready,
  output logic         busy,
  output logic         tx_done,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int W  = 16 / N;

  localparam logic [3:0]    PH_LAST = 4'(W - 1);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_READY = 3'd2;
  localparam logic [2:0] S_PRIME = 3'd3;
  localparam logic [2:0] S_SEND  = 3'd4;

  logic [2:0]    state;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [CW-1:0] word_count;
  logic [CW-1:0] out_words;
  logic [15:0]   ram_q;
  logic [15:0]   ram_out;
  logic [15:0]   shreg;
  logic [3:0]    fetch_ph;
  logic [3:0]    sym_cnt;
  logic          prime_cnt;

  logic accepting;
  logic wr_en;
  logic fetching;
  logic fetch_adv;
  logic last_sym;

  assign accepting   = (state == S_IDLE) || (state == S_FILL);
  assign wr_en       = accepting && axiiv && (word_count < FULL);
  assign wr_ready    = accepting;
  assign frame_ready = (state == S_READY);
  assign busy        = (state == S_PRIME) || (state == S_SEND);

  // The read address runs two cycles ahead of the shifter: word k is addressed
  // W*k cycles after tx_start, so its data lands exactly when word k-1 drains.
  assign fetching  = ((state == S_READY) && tx_start) || busy;
  assign fetch_adv = fetching && (fetch_ph == PH_LAST);
  assign last_sym  = (sym_cnt == PH_LAST);

  // Two-stage registered read path; contents are never cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= axiid;
    end
    ram_q   <= mem[rd_idx];
    ram_out <= ram_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wr_idx     <= '0;
      rd_idx     <= '0;
      word_count <= '0;
      out_words  <= '0;
      fetch_ph   <= '0;
      sym_cnt    <= '0;
      prime_cnt  <= 1'b0;
      shreg      <= '0;
      axiov      <= 1'b0;
      axiod      <= '0;
      tx_done    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      if (fetching) begin
        fetch_ph <= fetch_adv ? 4'd0 : fetch_ph + 4'd1;
        if (fetch_adv) begin
          rd_idx <= rd_idx + AW'(1);
        end
      end

      case (state)
        S_IDLE, S_FILL: begin
          if (axiiv) begin
            if (wr_en) begin
              wr_idx     <= wr_idx + AW'(1);
              word_count <= word_count + CW'(1);
            end
            // The first word of a frame starts a fresh overflow record.
            if (state == S_IDLE) begin
              overflow <= 1'b0;
            end else if (!wr_en) begin
              overflow <= 1'b1;
            end
            state <= axiil ? S_READY : S_FILL;
          end
        end

        S_READY: begin
          if (tx_start) begin
            state     <= S_PRIME;
            prime_cnt <= 1'b0;
          end
        end

        S_PRIME: begin
          prime_cnt <= 1'b1;
          if (prime_cnt) begin
            axiov     <= 1'b1;
            axiod     <= ram_out[15 -: N];
            shreg     <= ram_out << N;
            sym_cnt   <= 4'd0;
            out_words <= CW'(1);
            state     <= S_SEND;
          end
        end

        S_SEND: begin
          if (last_sym) begin
            if (out_words == word_count) begin
              axiov      <= 1'b0;
              axiod      <= '0;
              tx_done    <= 1'b1;
              state      <= S_IDLE;
              wr_idx     <= '0;
              rd_idx     <= '0;
              word_count <= '0;
              out_words  <= '0;
              fetch_ph   <= '0;
              sym_cnt    <= '0;
            end else begin
              axiod     <= ram_out[15 -: N];
              shreg     <= ram_out << N;
              sym_cnt   <= 4'd0;
              out_words <= out_words + CW'(1);
            end
          end else begin
            axiod   <= shreg[15 -: N];
            shreg   <= shreg << N;
            sym_cnt <= sym_cnt + 4'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_store_tx.sv
// Scoreboard bench for data_store_tx: one instance with N=2 and one with N=16,
// each with its own expected-symbol and expected-done queues.
module tb_data_store_tx;

  logic clk = 1'b0;
  logic rst;

  logic        axiiv2, axiil2, tx_start2;
  logic [15:0] axiid2;
  logic        wr_ready2, axiov2, frame_ready2, busy2, tx_done2, overflow2;
  logic [1:0]  axiod2;

  logic        axiiv16, axiil16, tx_start16;
  logic [15:0] axiid16;
  logic        wr_ready16, axiov16, frame_ready16, busy16, tx_done16, overflow16;
  logic [15:0] axiod16;

  data_store_tx #(.N(2), .DEPTH(256)) dut2 (
    .clk(clk), .rst(rst),
    .axiiv(axiiv2), .axiid(axiid2), .axiil(axiil2), .wr_ready(wr_ready2),
    .tx_start(tx_start2), .axiov(axiov2), .axiod(axiod2),
    .frame_ready(frame_ready2), .busy(busy2), .tx_done(tx_done2), .overflow(overflow2)
  );

  data_store_tx #(.N(16), .DEPTH(256)) dut16 (
    .clk(clk), .rst(rst),
    .axiiv(axiiv16), .axiid(axiid16), .axiil(axiil16), .wr_ready(wr_ready16),
    .tx_start(tx_start16), .axiov(axiov16), .axiod(axiod16),
    .frame_ready(frame_ready16), .busy(busy16), .tx_done(tx_done16), .overflow(overflow16)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] frame_buf [0:299];
  int sq2[$], cq2[$], dq2[$];
  int sq16[$], cq16[$], dq16[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic reportUnexpected(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endtask

  function automatic int sym_of(input logic [15:0] w, input int n, input int k);
    return (int'(w) >> (16 - (k + 1) * n)) & ((1 << n) - 1);
  endfunction

  // Monitors pop the scoreboard whenever a DUT presents a symbol or done pulse.
  always @(negedge clk) begin
    if (axiov2) begin
      if (sq2.size() == 0) reportUnexpected("sym2_unexpected");
      else begin
        checkOutput("sym2", int'(axiod2), sq2.pop_front());
        checkOutput("sym2_cycle", cyc, cq2.pop_front());
      end
    end
    if (tx_done2) begin
      if (dq2.size() == 0) reportUnexpected("done2_unexpected");
      else begin
        checkOutput("done2_cycle", cyc, dq2.pop_front());
        checkOutput("done2_axiod", int'(axiod2), 0);
      end
    end
    if (axiov16) begin
      if (sq16.size() == 0) reportUnexpected("sym16_unexpected");
      else begin
        checkOutput("sym16", int'(axiod16), sq16.pop_front());
        checkOutput("sym16_cycle", cyc, cq16.pop_front());
      end
    end
    if (tx_done16) begin
      if (dq16.size() == 0) reportUnexpected("done16_unexpected");
      else checkOutput("done16_cycle", cyc, dq16.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int n, input bit wide);
    for (int i = 0; i < n; i++) begin
      if (wide) begin
        axiiv16 = 1'b1; axiid16 = frame_buf[i]; axiil16 = (i == n - 1);
      end else begin
        axiiv2 = 1'b1; axiid2 = frame_buf[i]; axiil2 = (i == n - 1);
      end
      tick();
    end
    axiiv2 = 1'b0; axiil2 = 1'b0; axiiv16 = 1'b0; axiil16 = 1'b0;
  endtask

  task automatic startSend(input bit wide, output int t);
    t = cyc;
    if (wide) tx_start16 = 1'b1; else tx_start2 = 1'b1;
    tick();
    tx_start2 = 1'b0; tx_start16 = 1'b0;
  endtask

  task automatic pushModel2(input int nwords, input int t);
    for (int w = 0; w < nwords; w++)
      for (int k = 0; k < 8; k++) begin
        sq2.push_back(sym_of(frame_buf[w], 2, k));
        cq2.push_back(t + 3 + w * 8 + k);
      end
    dq2.push_back(t + 3 + nwords * 8);
  endtask

  task automatic drain(input int maxc);
    int k = 0;
    while ((sq2.size() + dq2.size() + sq16.size() + dq16.size()) != 0 && k < maxc) begin
      @(posedge clk);
      k++;
    end
    if ((sq2.size() + dq2.size() + sq16.size() + dq16.size()) != 0) begin
      reportUnexpected("drain_timeout");
      sq2.delete(); cq2.delete(); dq2.delete();
      sq16.delete(); cq16.delete(); dq16.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  int t;
  int exp3 [24] = '{2,2,1,1,3,0,0,3, 0,1,0,2,0,3,1,0, 3,3,3,3,3,3,3,3};
  int exp1 [8]  = '{2,0,0,0,0,0,0,1};
  int expr [6]  = '{3,0,0,3,2,2};
  int expn [8]  = '{1,0,3,2,1,3,0,2};

  initial begin
    rst = 1'b1;
    axiiv2 = 0; axiil2 = 0; axiid2 = 0; tx_start2 = 0;
    axiiv16 = 0; axiil16 = 0; axiid16 = 0; tx_start16 = 0;
    repeat (2) tick();
    checkOutput("rst_axiov", int'(axiov2), 0);
    checkOutput("rst_axiod", int'(axiod2), 0);
    checkOutput("rst_frame_ready", int'(frame_ready2), 0);
    checkOutput("rst_busy", int'(busy2), 0);
    checkOutput("rst_tx_done", int'(tx_done2), 0);
    checkOutput("rst_overflow", int'(overflow2), 0);
    checkOutput("rst_wr_ready", int'(wr_ready2), 1);
    checkOutput("rst_wr_ready16", int'(wr_ready16), 1);
    rst = 1'b0;

    // tx_start while idle must not start anything
    tx_start2 = 1'b1; tick(); tx_start2 = 1'b0;
    repeat (6) tick();
    checkOutput("idle_start_busy", int'(busy2), 0);

    // Three-word frame with hand-computed symbol stream
    frame_buf[0] = 16'hA5C3; frame_buf[1] = 16'h1234; frame_buf[2] = 16'hFFFF;
    applyStimulus(3, 1'b0);
    checkOutput("f3_frame_ready", int'(frame_ready2), 1);
    checkOutput("f3_wr_ready", int'(wr_ready2), 0);
    startSend(1'b0, t);
    for (int i = 0; i < 24; i++) begin
      sq2.push_back(exp3[i]);
      cq2.push_back(t + 3 + i);
    end
    dq2.push_back(t + 27);
    checkOutput("f3_busy", int'(busy2), 1);
    axiiv2 = 1'b1; axiid2 = 16'hDEAD;
    repeat (8) tick();
    axiiv2 = 1'b0;
    drain(100);
    checkOutput("f3_wr_ready_after", int'(wr_ready2), 1);
    checkOutput("f3_busy_after", int'(busy2), 0);

    // Single-word frame; tx_start coincident with axiil is ignored
    axiiv2 = 1'b1; axiid2 = 16'h8001; axiil2 = 1'b1; tx_start2 = 1'b1;
    tick();
    axiiv2 = 1'b0; axiil2 = 1'b0; tx_start2 = 1'b0;
    checkOutput("f1_frame_ready", int'(frame_ready2), 1);
    repeat (3) tick();
    checkOutput("f1_still_ready", int'(frame_ready2), 1);
    checkOutput("f1_not_busy", int'(busy2), 0);
    startSend(1'b0, t);
    for (int i = 0; i < 8; i++) begin
      sq2.push_back(exp1[i]);
      cq2.push_back(t + 3 + i);
    end
    dq2.push_back(t + 11);
    drain(50);

    // 258 words: last two dropped, 256 words streamed
    for (int i = 0; i < 258; i++) frame_buf[i] = 16'((i * 257) ^ 16'h3C5A);
    applyStimulus(258, 1'b0);
    checkOutput("ovf_set", int'(overflow2), 1);
    checkOutput("ovf_frame_ready", int'(frame_ready2), 1);
    startSend(1'b0, t);
    pushModel2(256, t);
    drain(2200);
    checkOutput("ovf_sticky", int'(overflow2), 1);

    // Reset five cycles into SEND
    frame_buf[0] = 16'hC3A5; frame_buf[1] = 16'h0F0F;
    applyStimulus(2, 1'b0);
    checkOutput("ovf_cleared", int'(overflow2), 0);
    startSend(1'b0, t);
    for (int i = 0; i < 6; i++) begin
      sq2.push_back(expr[i]);
      cq2.push_back(t + 3 + i);
    end
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_mid_axiov", int'(axiov2), 0);
    checkOutput("rst_mid_wr_ready", int'(wr_ready2), 1);
    checkOutput("rst_mid_busy", int'(busy2), 0);
    checkOutput("rst_mid_sb_empty", sq2.size(), 0);
    frame_buf[0] = 16'h4E72;
    applyStimulus(1, 1'b0);
    startSend(1'b0, t);
    for (int i = 0; i < 8; i++) begin
      sq2.push_back(expn[i]);
      cq2.push_back(t + 3 + i);
    end
    dq2.push_back(t + 11);
    drain(50);

    // N=16: one word per cycle with no gap
    frame_buf[0] = 16'h1111; frame_buf[1] = 16'hBEEF;
    frame_buf[2] = 16'h0000; frame_buf[3] = 16'hF00D;
    applyStimulus(4, 1'b1);
    checkOutput("n16_frame_ready", int'(frame_ready16), 1);
    startSend(1'b1, t);
    sq16.push_back(16'h1111); cq16.push_back(t + 3);
    sq16.push_back(16'hBEEF); cq16.push_back(t + 4);
    sq16.push_back(16'h0000); cq16.push_back(t + 5);
    sq16.push_back(16'hF00D); cq16.push_back(t + 6);
    dq16.push_back(t + 7);
    drain(50);
    checkOutput("n16_idle", int'(wr_ready16), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
